// File: rtl/clk_div_pkg.sv
// ============================================================================
// clk_div_pkg : shared types and defaults for the divided-clock controller
// Rev 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

    localparam int unsigned CNT_W_DEF        = 32;
    localparam int unsigned DEFAULT_HALF_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/clk_div_cfg_slot.sv
// ============================================================================
// clk_div_cfg_slot : one-entry pending-ratio register with zero rejection
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_div_cfg_slot
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             consume,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             pend_valid,
    output logic [CNT_W-1:0] pend_half
);

    logic             full_q, full_d;
    logic [CNT_W-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             w_handshake;

    assign w_handshake = cfg_valid && !full_q;

    // Handshake needs an empty slot and consume needs a full one, so the two
    // never coincide: a ratio accepted on an apply cycle waits for the next.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        err_d  = 1'b0;
        if (consume) begin
            full_d = 1'b0;
        end else if (w_handshake) begin
            if (cfg_half == '0) begin
                err_d = 1'b1;
            end else begin
                full_d = 1'b1;
                data_d = cfg_half;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign cfg_ready  = !full_q;
    assign cfg_err    = err_q;
    assign pend_valid = full_q;
    assign pend_half  = data_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ============================================================================
// clk_div_ctrl : run-time divided-clock generator with glitch-free start/stop
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             active
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             div_clk_q, div_clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             apply;
    logic             pend_valid;
    logic [CNT_W-1:0] pend_half;
    logic             w_term;

    clk_div_cfg_slot #(
        .CNT_W (CNT_W)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_half   (cfg_half),
        .consume    (apply),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .pend_valid (pend_valid),
        .pend_half  (pend_half)
    );

    assign w_term = (cnt_q == (half_q - CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            half_q    <= CNT_W'(DEFAULT_HALF);
            div_clk_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            div_clk_q <= div_clk_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (w_term && !div_clk_q) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counter, ratio update and registered clock/tick levels.
    always_comb begin
        cnt_d     = cnt_q;
        half_d    = half_q;
        div_clk_d = div_clk_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        apply     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                div_clk_d = 1'b0;
                if (pend_valid) begin
                    apply  = 1'b1;
                    half_d = pend_half;
                end
                if (en) begin
                    div_clk_d = 1'b1;
                    rise_d    = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (w_term) begin
                    cnt_d = '0;
                    if (div_clk_q) begin
                        div_clk_d = 1'b0;
                        fall_d    = 1'b1;
                    end else if ((state_q == ST_RUN) || en) begin
                        // A draining generator with en low swallows this rise.
                        div_clk_d = 1'b1;
                        rise_d    = 1'b1;
                        if (pend_valid) begin
                            apply  = 1'b1;
                            half_d = pend_half;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d     = '0;
                div_clk_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        div_clk   = div_clk_q;
        rise_tick = rise_q;
        fall_tick = fall_q;
        active    = (state_q != ST_IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ============================================================================
// tb_clk_div_ctrl : directed self-checking bench for clk_div_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_clk;
    logic             rise_tick;
    logic             fall_tick;
    logic             active;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_ctrl #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_clk   (div_clk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Length of the current div_clk phase, counting the present cycle; 0 on timeout.
    task automatic measure(input logic lvl, output int n);
        bit done;
        done = 1'b0;
        n    = 1;
        while (!done && n < 64) begin
            cyc();
            if (div_clk === lvl) n++;
            else done = 1'b1;
        end
        if (!done) n = 0;
    endtask

    task automatic sync_rise();
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (rise_tick !== 1'b1 && k < 64);
        check("sync_rise", rise_tick, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int ticks;

        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
        cyc(); cyc();
        check("rst_div_clk", div_clk, 0);
        check("rst_rise", rise_tick, 0);
        check("rst_fall", fall_tick, 0);
        check("rst_err", cfg_err, 0);
        check("rst_active", active, 0);
        check("rst_ready", cfg_ready, 1);

        // Default divide-by-10
        rst = 1'b0;
        cyc();
        check("idle_div_clk", div_clk, 0);
        en = 1'b1;
        cyc();
        check("start_rise", rise_tick, 1);
        check("start_div_clk", div_clk, 1);
        check("start_active", active, 1);
        measure(1'b1, n); check("def_high", n, 5);
        check("def_fall_tick", fall_tick, 1);
        measure(1'b0, n); check("def_low", n, 5);
        check("def_rise_tick", rise_tick, 1);

        // Ratio 3 offered in the third high cycle
        cyc(); cyc();
        cfg_valid = 1'b1; cfg_half = 3;
        cyc();
        check("mid_ready_low", cfg_ready, 0);
        cfg_valid = 1'b0;
        cyc(); cyc();
        check("mid_fall_tick", fall_tick, 1);
        check("mid_ready_still_low", cfg_ready, 0);
        measure(1'b0, n); check("mid_old_low", n, 5);
        check("mid_ready_back", cfg_ready, 1);
        measure(1'b1, n); check("mid_new_high", n, 3);
        measure(1'b0, n); check("mid_new_low", n, 3);

        // Zero ratio rejected
        cfg_valid = 1'b1; cfg_half = 0;
        cyc();
        check("zero_err", cfg_err, 1);
        check("zero_ready", cfg_ready, 1);
        cfg_valid = 1'b0;
        cyc();
        check("zero_err_clear", cfg_err, 0);
        cyc();
        check("zero_fall_tick", fall_tick, 1);
        measure(1'b0, n); check("zero_low", n, 3);
        measure(1'b1, n); check("zero_high", n, 3);

        // Back to 5, then stop two cycles into the high phase
        cfg_valid = 1'b1; cfg_half = 5;
        cyc();
        cfg_valid = 1'b0;
        sync_rise();
        cyc();
        en = 1'b0;
        measure(1'b1, n); check("stop_high_rest", n, 4);
        check("stop_active_fall", active, 1);
        for (int i = 0; i < 4; i++) cyc();
        check("stop_active_low5", active, 1);
        check("stop_div_low5", div_clk, 0);
        cyc();
        check("stop_idle_active", active, 0);
        check("stop_idle_div", div_clk, 0);
        check("stop_idle_rise", rise_tick, 0);
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            ticks += int'(rise_tick);
        end
        check("stop_no_rise", ticks, 0);

        // Stop, then resume during the low phase of the drain
        en = 1'b1;
        cyc();
        check("resume_start_rise", rise_tick, 1);
        cyc();
        en = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        check("resume_fall_tick", fall_tick, 1);
        cyc();
        en = 1'b1;
        measure(1'b0, n); check("resume_low_rest", n, 4);
        check("resume_rise_tick", rise_tick, 1);
        measure(1'b1, n); check("resume_high", n, 5);
        check("resume_active", active, 1);

        // Ratio 1 loaded in IDLE
        en = 1'b0;
        k = 0;
        while (active === 1'b1 && k < 64) begin
            cyc();
            k++;
        end
        check("idle_reached", active, 0);
        cfg_valid = 1'b1; cfg_half = 1;
        cyc();
        check("idle_ready_low", cfg_ready, 0);
        cfg_valid = 1'b0;
        cyc();
        check("idle_ready_back", cfg_ready, 1);
        en = 1'b1;
        cyc();
        check("fast_div1", div_clk, 1);
        check("fast_rise1", rise_tick, 1);
        cyc();
        check("fast_div2", div_clk, 0);
        check("fast_fall2", fall_tick, 1);
        check("fast_rise2", rise_tick, 0);
        cyc();
        check("fast_div3", div_clk, 1);
        check("fast_rise3", rise_tick, 1);
        check("fast_fall3", fall_tick, 0);

        // Offer coinciding with a rise waits; reset while it is pending
        cyc();
        check("coin_low", div_clk, 0);
        cfg_valid = 1'b1; cfg_half = 7;
        cyc();
        check("coin_rise", div_clk, 1);
        check("coin_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        cyc();
        check("coin_old_half", div_clk, 0);
        check("coin_pending", cfg_ready, 0);
        rst = 1'b1;
        #1;
        check("arst_div", div_clk, 0);
        check("arst_fall", fall_tick, 0);
        check("arst_active", active, 0);
        check("arst_ready", cfg_ready, 1);
        cyc();
        rst = 1'b0;
        cyc();
        check("post_rst_rise", rise_tick, 1);
        measure(1'b1, n); check("post_rst_high", n, 5);
        measure(1'b0, n); check("post_rst_low", n, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
